// File: rtl/bram_access_arbiter.sv
// bram_access_arbiter: shares one BRAM port between the AXI-Lite bridge
// (requester 0) and the simplex compute core (requester 1).
// Round-robin arbitration, a core lock for multi-access pivot sequences,
// and a read tag pipeline that steers read data back to its issuer.
//
// Ports:
//   ACLK, ARESETN              clock, asynchronous active-low reset
//   axi_req_*  / axi_resp_*    requester 0 request and read response
//   core_req_* / core_resp_*   requester 1 request and read response
//   core_lock                  core holds exclusive ownership while high
//   bram_en/we/addr/din        registered BRAM issue port
//   bram_dout                  BRAM read data, valid RD_LATENCY cycles after bram_en
module bram_access_arbiter #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    axi_req_valid,
  output logic                    axi_req_ready,
  input  logic                    axi_req_we,
  input  logic [ADDR_WIDTH-1:0]   axi_req_addr,
  input  logic [DATA_WIDTH-1:0]   axi_req_wdata,
  output logic                    axi_resp_valid,
  output logic [DATA_WIDTH-1:0]   axi_resp_rdata,
  input  logic                    core_req_valid,
  output logic                    core_req_ready,
  input  logic                    core_req_we,
  input  logic [ADDR_WIDTH-1:0]   core_req_addr,
  input  logic [DATA_WIDTH-1:0]   core_req_wdata,
  input  logic                    core_lock,
  output logic                    core_resp_valid,
  output logic [DATA_WIDTH-1:0]   core_resp_rdata,
  output logic                    bram_en,
  output logic [DATA_WIDTH/8-1:0] bram_we,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [DATA_WIDTH-1:0]   bram_din,
  input  logic [DATA_WIDTH-1:0]   bram_dout
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  typedef enum logic {
    ST_RR     = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                  r_state;
  logic                    r_last_core;
  logic                    r_bram_en;
  logic [BE_W-1:0]         r_bram_we;
  logic [ADDR_WIDTH-1:0]   r_bram_addr;
  logic [DATA_WIDTH-1:0]   r_bram_din;
  logic [RD_LATENCY-1:0]   r_tag_vld;
  logic [RD_LATENCY-1:0]   r_tag_id;
  logic                    r_axi_resp_valid;
  logic                    r_core_resp_valid;
  logic [DATA_WIDTH-1:0]   r_axi_rdata;
  logic [DATA_WIDTH-1:0]   r_core_rdata;

  logic                    w_locked;
  logic                    w_axi_gnt;
  logic                    w_core_gnt;
  logic                    w_accept;
  logic                    w_issue_we;
  logic [ADDR_WIDTH-1:0]   w_issue_addr;
  logic [DATA_WIDTH-1:0]   w_issue_wdata;
  logic                    w_rd_accept;
  logic [RD_LATENCY-1:0]   w_tag_vld_nxt;
  logic [RD_LATENCY-1:0]   w_tag_id_nxt;

  // Lock only excludes AXI while it is still held; the cycle it drops arbitrates as RR.
  assign w_locked   = (r_state == ST_LOCKED) && core_lock;
  assign w_axi_gnt  = axi_req_valid && !w_locked && (!core_req_valid || r_last_core);
  assign w_core_gnt = core_req_valid && (w_locked || !axi_req_valid || !r_last_core);

  assign axi_req_ready  = w_axi_gnt;
  assign core_req_ready = w_core_gnt;

  assign w_accept      = w_axi_gnt || w_core_gnt;
  assign w_issue_we    = w_axi_gnt ? axi_req_we    : core_req_we;
  assign w_issue_addr  = w_axi_gnt ? axi_req_addr  : core_req_addr;
  assign w_issue_wdata = w_axi_gnt ? axi_req_wdata : core_req_wdata;
  assign w_rd_accept   = w_accept && !w_issue_we;

  // Tag shift input; the tag reaching the top bit drives the response register.
  generate
    if (RD_LATENCY == 1) begin : g_tag_l1
      assign w_tag_vld_nxt = w_rd_accept;
      assign w_tag_id_nxt  = w_core_gnt;
    end else begin : g_tag_ln
      assign w_tag_vld_nxt = {r_tag_vld[RD_LATENCY-2:0], w_rd_accept};
      assign w_tag_id_nxt  = {r_tag_id[RD_LATENCY-2:0], w_core_gnt};
    end
  endgenerate

  // Arbitration state: lock FSM and round-robin pointer.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= ST_RR;
      r_last_core <= 1'b1;
    end else begin
      if (w_axi_gnt) begin
        r_last_core <= 1'b0;
      end else if (w_core_gnt) begin
        r_last_core <= 1'b1;
      end
      if (w_core_gnt && core_lock) begin
        r_state <= ST_LOCKED;
      end else if (!core_lock) begin
        r_state <= ST_RR;
      end
    end
  end

  // BRAM issue registers; address and data hold when idle.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_bram_en   <= 1'b0;
      r_bram_we   <= '0;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
    end else if (w_accept) begin
      r_bram_en   <= 1'b1;
      r_bram_we   <= w_issue_we ? {BE_W{1'b1}} : {BE_W{1'b0}};
      r_bram_addr <= w_issue_addr;
      r_bram_din  <= w_issue_wdata;
    end else begin
      r_bram_en   <= 1'b0;
      r_bram_we   <= '0;
    end
  end

  // Read tag pipeline and response routing.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_tag_vld         <= '0;
      r_tag_id          <= '0;
      r_axi_resp_valid  <= 1'b0;
      r_core_resp_valid <= 1'b0;
      r_axi_rdata       <= '0;
      r_core_rdata      <= '0;
    end else begin
      r_tag_vld         <= w_tag_vld_nxt;
      r_tag_id          <= w_tag_id_nxt;
      r_axi_resp_valid  <= r_tag_vld[RD_LATENCY-1] && !r_tag_id[RD_LATENCY-1];
      r_core_resp_valid <= r_tag_vld[RD_LATENCY-1] && r_tag_id[RD_LATENCY-1];
      if (r_axi_resp_valid) begin
        r_axi_rdata <= bram_dout;
      end
      if (r_core_resp_valid) begin
        r_core_rdata <= bram_dout;
      end
    end
  end

  assign bram_en   = r_bram_en;
  assign bram_we   = r_bram_we;
  assign bram_addr = r_bram_addr;
  assign bram_din  = r_bram_din;

  assign axi_resp_valid  = r_axi_resp_valid;
  assign core_resp_valid = r_core_resp_valid;

  // BRAM data is valid in the response cycle itself: pass it through on the
  // pulse, then hold the captured word until that requester's next response.
  assign axi_resp_rdata  = r_axi_resp_valid  ? bram_dout : r_axi_rdata;
  assign core_resp_rdata = r_core_resp_valid ? bram_dout : r_core_rdata;

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Testbench for bram_access_arbiter: two instances (RD_LATENCY 1 and 3) see the
// same requests; a reference arbiter model and per-instance response scoreboards
// check grants, BRAM issue and routed read data every cycle.
module tb_bram_access_arbiter;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int NL   = 2;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          lock;
  } req_t;

  typedef struct {
    int            due;
    logic          id;
    logic [DW-1:0] data;
  } rsp_t;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b1;
  logic          axi_req_valid = 1'b0;
  logic          axi_req_we = 1'b0;
  logic [AW-1:0] axi_req_addr = '0;
  logic [DW-1:0] axi_req_wdata = '0;
  logic          core_req_valid = 1'b0;
  logic          core_req_we = 1'b0;
  logic [AW-1:0] core_req_addr = '0;
  logic [DW-1:0] core_req_wdata = '0;
  logic          core_lock = 1'b0;

  logic          l_axi_ready [NL];
  logic          l_core_ready [NL];
  logic          l_axi_rv [NL];
  logic          l_core_rv [NL];
  logic [DW-1:0] l_axi_rd [NL];
  logic [DW-1:0] l_core_rd [NL];
  logic          l_en [NL];
  logic [BW-1:0] l_we [NL];
  logic [AW-1:0] l_addr [NL];
  logic [DW-1:0] l_din [NL];
  logic [DW-1:0] l_dout [NL];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  req_t axi_q[$];
  req_t core_q[$];
  rsp_t sb0[$];
  rsp_t sb1[$];
  logic [DW-1:0] shadow [int];

  logic          m_last_core;
  logic          m_locked;
  logic          m_en;
  logic [BW-1:0] m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [DW-1:0] m_hold [NL][2];

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ DW'(a);
  endfunction

  function automatic logic [DW-1:0] rd_shadow(input logic [AW-1:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : init_word(a);
  endfunction

  function automatic string tg(input int ln, input string s);
    return $sformatf("L%0d %s", ln, s);
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int LAT = (g == 0) ? LAT0 : LAT1;
    logic [DW-1:0] mem [int];
    logic [DW-1:0] pipe [LAT];

    bram_access_arbiter #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .RD_LATENCY(LAT)
    ) u_dut (
      .ACLK           (ACLK),
      .ARESETN        (ARESETN),
      .axi_req_valid  (axi_req_valid),
      .axi_req_ready  (l_axi_ready[g]),
      .axi_req_we     (axi_req_we),
      .axi_req_addr   (axi_req_addr),
      .axi_req_wdata  (axi_req_wdata),
      .axi_resp_valid (l_axi_rv[g]),
      .axi_resp_rdata (l_axi_rd[g]),
      .core_req_valid (core_req_valid),
      .core_req_ready (l_core_ready[g]),
      .core_req_we    (core_req_we),
      .core_req_addr  (core_req_addr),
      .core_req_wdata (core_req_wdata),
      .core_lock      (core_lock),
      .core_resp_valid(l_core_rv[g]),
      .core_resp_rdata(l_core_rd[g]),
      .bram_en        (l_en[g]),
      .bram_we        (l_we[g]),
      .bram_addr      (l_addr[g]),
      .bram_din       (l_din[g]),
      .bram_dout      (l_dout[g])
    );

    // Behavioural BRAM: read-first, data valid LAT cycles after the enable cycle.
    always @(posedge ACLK) begin
      logic [DW-1:0] rv;
      rv = mem.exists(int'(l_addr[g])) ? mem[int'(l_addr[g])] : init_word(l_addr[g]);
      pipe[0] <= rv;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      if (l_en[g] && (l_we[g] != '0)) mem[int'(l_addr[g])] = l_din[g];
    end
    assign l_dout[g] = pipe[LAT-1];
  end

  task automatic check_outputs();
    rsp_t h;
    logic due;
    for (int ln = 0; ln < NL; ln++) begin
      h = '{due: 0, id: 1'b0, data: '0};
      due = 1'b0;
      check_val(tg(ln, "bram_en"),   64'(l_en[ln]),   64'(m_en));
      check_val(tg(ln, "bram_we"),   64'(l_we[ln]),   64'(m_we));
      check_val(tg(ln, "bram_addr"), 64'(l_addr[ln]), 64'(m_addr));
      check_val(tg(ln, "bram_din"),  64'(l_din[ln]),  64'(m_din));
      if (ln == 0 && sb0.size() > 0 && sb0[0].due <= cyc) begin
        h = sb0.pop_front();
        due = 1'b1;
      end
      if (ln == 1 && sb1.size() > 0 && sb1[0].due <= cyc) begin
        h = sb1.pop_front();
        due = 1'b1;
      end
      check_val(tg(ln, "axi_resp_valid"),  64'(l_axi_rv[ln]),  64'(due && !h.id));
      check_val(tg(ln, "core_resp_valid"), 64'(l_core_rv[ln]), 64'(due && h.id));
      if (due) m_hold[ln][h.id] = h.data;
      check_val(tg(ln, "axi_resp_rdata"),  64'(l_axi_rd[ln]),  64'(m_hold[ln][0]));
      check_val(tg(ln, "core_resp_rdata"), 64'(l_core_rd[ln]), 64'(m_hold[ln][1]));
    end
  endtask

  // One clock cycle: check registered outputs, drive requests, check grants, update model.
  task automatic do_cycle();
    logic av, cv, lk, ag, cg;
    req_t r;
    @(negedge ACLK);
    check_outputs();
    av = (axi_q.size() > 0);
    cv = (core_q.size() > 0);
    lk = cv ? core_q[0].lock : 1'b0;
    axi_req_valid = av;
    if (av) begin
      axi_req_we    = axi_q[0].we;
      axi_req_addr  = axi_q[0].addr;
      axi_req_wdata = axi_q[0].data;
    end
    core_req_valid = cv;
    if (cv) begin
      core_req_we    = core_q[0].we;
      core_req_addr  = core_q[0].addr;
      core_req_wdata = core_q[0].data;
    end
    core_lock = lk;
    #1;
    ag = av && !(m_locked && lk) && (!cv || m_last_core);
    cg = cv && !ag;
    for (int ln = 0; ln < NL; ln++) begin
      check_val(tg(ln, "axi_req_ready"),  64'(l_axi_ready[ln]),  64'(ag));
      check_val(tg(ln, "core_req_ready"), 64'(l_core_ready[ln]), 64'(cg));
    end
    m_en = ag || cg;
    m_we = '0;
    if (ag || cg) begin
      if (ag) r = axi_q.pop_front();
      else    r = core_q.pop_front();
      m_addr = r.addr;
      m_din  = r.data;
      m_we   = r.we ? {BW{1'b1}} : {BW{1'b0}};
      m_last_core = cg;
      if (r.we) begin
        shadow[int'(r.addr)] = r.data;
      end else begin
        sb0.push_back('{due: cyc + 1 + LAT0, id: cg, data: rd_shadow(r.addr)});
        sb1.push_back('{due: cyc + 1 + LAT1, id: cg, data: rd_shadow(r.addr)});
      end
    end
    if (cg && lk) m_locked = 1'b1;
    else if (!lk) m_locked = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESETN = 1'b0;
    axi_req_valid  = 1'b0;
    core_req_valid = 1'b0;
    core_lock      = 1'b0;
    axi_q.delete();
    core_q.delete();
    sb0.delete();
    sb1.delete();
    m_last_core = 1'b1;
    m_locked    = 1'b0;
    m_en        = 1'b0;
    m_we        = '0;
    m_addr      = '0;
    m_din       = '0;
    for (int ln = 0; ln < NL; ln++) begin
      m_hold[ln][0] = '0;
      m_hold[ln][1] = '0;
    end
    #1;
    check_outputs();
    @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((axi_q.size() > 0 || core_q.size() > 0 || sb0.size() > 0 ||
            sb1.size() > 0 || m_en) && n < max_cyc) begin
      do_cycle();
      n++;
    end
    check_val("drain_in_budget", 64'(n < max_cyc), 64'(1));
    do_cycle();
  endtask

  task automatic push_axi(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    axi_q.push_back('{we: we, addr: a, data: d, lock: 1'b0});
  endtask

  task automatic push_core(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic lk);
    core_q.push_back('{we: we, addr: a, data: d, lock: lk});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    do_cycle();
    do_cycle();

    // Tie: both hold reads, grants alternate starting with AXI.
    for (int i = 0; i < 3; i++) begin
      push_axi(1'b0, AW'(14'h010), $urandom);
      push_core(1'b0, AW'(14'h020), $urandom, 1'b0);
    end
    drain(40);

    // AXI write then immediate read-back of the same address.
    push_axi(1'b1, AW'(14'h004), 32'h0000_0002);
    push_axi(1'b0, AW'(14'h004), $urandom);
    drain(40);

    // Core lock with 4 writes while AXI waits on a read.
    for (int i = 0; i < 4; i++) push_core(1'b1, AW'(14'h100 + i), 32'hBEEF_0000 + i, 1'b1);
    push_axi(1'b0, AW'(14'h000), $urandom);
    drain(40);
    for (int i = 0; i < 4; i++) push_core(1'b0, AW'(14'h100 + i), $urandom, 1'b0);
    drain(40);

    // Alternating reads of 0x8 / 0x9.
    for (int i = 0; i < 4; i++) begin
      push_axi(1'b0, AW'(14'h008), $urandom);
      push_core(1'b0, AW'(14'h009), $urandom, 1'b0);
    end
    drain(40);

    // Random mix of reads, writes and lock sequences.
    for (int i = 0; i < 300; i++) begin
      if (axi_q.size() == 0 && $urandom_range(0, 2) != 0)
        push_axi(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
      if (core_q.size() == 0 && $urandom_range(0, 2) != 0)
        push_core(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 3) == 0));
      do_cycle();
    end
    drain(100);

    // Reset with reads in flight, then a tie right after reset.
    push_axi(1'b0, AW'(14'h010), $urandom);
    push_core(1'b0, AW'(14'h020), $urandom, 1'b0);
    do_cycle();
    do_cycle();
    do_reset();
    push_axi(1'b0, AW'(14'h030), $urandom);
    push_core(1'b0, AW'(14'h031), $urandom, 1'b0);
    drain(40);
    for (int i = 0; i < 6; i++) do_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_access_arbiter.md
Name: bram_access_arbiter

Overview:
- Shares the single BRAM port behind the AXI-Lite slave between two requesters.
- Requester 0 is the AXI-Lite register/BRAM bridge (host loads the tableau and reads results).
- Requester 1 is the simplex compute core.
- Round-robin arbitration, plus a core lock so the core can own the port for multi-access pivot sequences; read data is routed back to the issuing requester.

Parameters:
ADDR_WIDTH, 14, BRAM word address width
DATA_WIDTH, 32, BRAM data width (multiple of 8)
RD_LATENCY, 1, BRAM read latency in cycles from bram_en to valid bram_dout (legal 1..3)

Ports:
ACLK  in  1  clock, all logic rising-edge
ARESETN  in  1  asynchronous active-low reset
axi_req_valid  in  1  requester 0 access request
axi_req_ready  out  1  requester 0 request accepted this cycle
axi_req_we  in  1  1 = write, 0 = read
axi_req_addr  in  ADDR_WIDTH  word address
axi_req_wdata  in  DATA_WIDTH  write data
axi_resp_valid  out  1  read data valid for requester 0 (1-cycle pulse)
axi_resp_rdata  out  DATA_WIDTH  read data
core_req_valid/core_req_ready/core_req_we/core_req_addr/core_req_wdata  same as axi_* for requester 1
core_lock  in  1  core requests exclusive ownership while high
core_resp_valid  out  1  read data valid for requester 1
core_resp_rdata  out  DATA_WIDTH  read data
bram_en  out  1  BRAM enable
bram_we  out  DATA_WIDTH/8  byte write enables (all ones on write, zero on read)
bram_addr  out  ADDR_WIDTH  BRAM address
bram_din  out  DATA_WIDTH  BRAM write data
bram_dout  in  DATA_WIDTH  BRAM read data

Behaviour:
- Reset (ARESETN low, async):
  - bram_en, bram_we, bram_addr, bram_din, both resp_valid and both rdata outputs are 0.
  - Round-robin pointer last_grant = core, so AXI wins the first tie.
  - State RR; in-flight tag pipeline cleared.
- Reset mid-operation: all outstanding reads are dropped; no resp_valid after deassertion for pre-reset requests.
- Handshake: a request is accepted in the cycle where valid and ready are both high.
  - ready is combinational from the valid inputs and state; at most one ready is high per cycle.
  - A requester holds valid, we, addr and wdata stable until accepted.
- State RR:
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant. last_grant updates on every accept.
  - Core accepted with core_lock = 1: go to LOCKED.
- State LOCKED:
  - axi_req_ready = 0; core_req_ready = core_req_valid.
  - Go to RR on the first cycle core_lock is sampled 0; that same cycle arbitrates as in RR.
  - core_lock high while in RR and the core is not granted has no effect until the core wins a grant.
- Issue: on accept in cycle N, bram_en = 1 and bram_addr/bram_din/bram_we are registered and valid in cycle N+1. With no accept, bram_en = 0, bram_we = 0, address and data hold.
- Back-to-back: one access per cycle sustained, with no bubble between grants.
- Read return:
  - A tag {valid, id} is shifted through a RD_LATENCY-deep pipeline.
  - For a read accepted in cycle N, the issuer's resp_valid pulses in cycle N+1+RD_LATENCY.
  - Its rdata equals bram_dout, registered into that requester's rdata output only on its own response; the output holds otherwise.
  - Writes produce no response.
- Ordering: responses return in issue order. Reads and writes to the same address are BRAM-ordered; a read accepted the cycle after a write to the same address returns the new data (BRAM read-first/write-first has no effect since they are separate cycles).
- No backpressure on responses: requesters must accept resp_valid whenever it pulses.

Test Plan:
- Single AXI write addr 0x004 data 0x00000002, then AXI read 0x004 with RD_LATENCY=1 -> bram_en high the cycle after each accept; axi_resp_valid 2 cycles after the read accept with rdata 0x00000002; core_resp_valid stays 0.
- Both requesters hold valid reads for 6 cycles, addresses 0x10 (AXI) and 0x20 (core) -> grants alternate AXI, core, AXI…; 3 responses each, in order, each with the correct rdata.
- Core asserts core_lock with 4 back-to-back writes (0x100..0x103) while AXI holds a read of 0x000 valid -> axi_req_ready stays 0 for all 4; AXI is accepted the cycle core_lock drops.
- RD_LATENCY=3, alternating AXI read 0x8 / core read 0x9 each cycle -> each resp_valid pulses exactly 4 cycles after its accept, with no cross-routing of data.
- Assert ARESETN low for 1 cycle with 2 reads in flight -> all outputs 0 immediately; no resp_valid afterwards; first post-reset tie is granted to AXI.
